// File: rtl/me_result_drain.sv
// ---------------------------------------------------------------------------
// me_result_drain
//
// Captures one modular-exponentiation result (z, job tag) on a done pulse and
// streams it out as NWORDS = M_SIZE/OUT_WIDTH beats over a valid/ready
// handshake, least-significant word first. A done pulse that arrives while a
// result is still streaming is dropped and recorded in a sticky overflow flag,
// except when it coincides with the handshake of the last beat, in which case
// the new result is chained in with no idle gap.
//
// Optional feature: define ME_DRAIN_HDR_EN to emit one header beat ahead of
// the data beats (out_data[NUM_W-1:0] = tag, out_data[15:8] = NWORDS).
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   done       one-cycle result-valid pulse from the ME top
//   z          ME result, sampled when done=1
//   num_out    job tag, sampled when done=1
//   out_data   current output beat
//   out_valid  out_data is valid
//   out_ready  downstream accepts the beat
//   out_last   final beat of a result
//   out_num    captured tag, constant over a result
//   busy       a captured result is being streamed
//   overflow   sticky: a done pulse was dropped
//   clr_ovf    synchronous clear of overflow
// ---------------------------------------------------------------------------
module me_result_drain #(
   parameter int M_SIZE    = 3072,
   parameter int OUT_WIDTH = 64,
   parameter int NUM_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 done,
   input  logic [M_SIZE-1:0]    z,
   input  logic [NUM_W-1:0]     num_out,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [NUM_W-1:0]     out_num,
   output logic                 busy,
   output logic                 overflow,
   input  logic                 clr_ovf
);

   localparam int NWORDS = M_SIZE / OUT_WIDTH;
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

`ifdef ME_DRAIN_HDR_EN
   localparam logic [7:0] NW8 = 8'(NWORDS);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_DATA = 2'd2} state_t;
   localparam state_t ST_FIRST = ST_HDR;
`else
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;
   localparam state_t ST_FIRST = ST_DATA;
`endif

   state_t                           state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [NWORDS-1:0][OUT_WIDTH-1:0] z_q, z_d;
   logic [NUM_W-1:0]                 num_q, num_d;
   logic                             ovf_q, ovf_d;
   logic                             hs_s, last_s, drop_s;

   // Output decode from the registered state, counter and captured result
   always_comb begin
      out_data  = '0;
      out_last  = 1'b0;
      out_valid = (state_q != ST_IDLE);
      busy      = (state_q != ST_IDLE);
      out_num   = num_q;
      overflow  = ovf_q;
      case (state_q)
         ST_DATA: begin
            out_data = z_q[cnt_q];
            out_last = (cnt_q == LAST_IDX);
         end
`ifdef ME_DRAIN_HDR_EN
         ST_HDR: begin
            out_data[15:8]      = NW8;
            out_data[NUM_W-1:0] = num_q;
         end
`endif
         default: begin
            out_data = '0;
            out_last = 1'b0;
         end
      endcase
   end

   // Next-state, capture, beat counter and drop detection
   always_comb begin
      hs_s    = out_valid & out_ready;
      last_s  = (state_q == ST_DATA) && (cnt_q == LAST_IDX);
      state_d = state_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      num_d   = num_q;
      drop_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (done) begin
               z_d     = z;
               num_d   = num_out;
               cnt_d   = '0;
               state_d = ST_FIRST;
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef ME_DRAIN_HDR_EN
         ST_HDR: begin
            if (hs_s) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end else begin
               state_d = ST_HDR;
            end
            drop_s = done;
         end
`endif
         ST_DATA: begin
            if (hs_s && last_s) begin
               // A done on the final handshake chains the next result in
               if (done) begin
                  z_d     = z;
                  num_d   = num_out;
                  cnt_d   = '0;
                  state_d = ST_FIRST;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (hs_s) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = cnt_q;
               end
               drop_s = done;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Set wins over clear when both happen in the same cycle
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State, counter, captured result and sticky overflow registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         z_q     <= '0;
         num_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         num_q   <= num_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_me_result_drain.sv
// ---------------------------------------------------------------------------
// tb_me_result_drain
//
// Directed sequence with randomized data/ready, checked against a queue model
// of the beats each captured result must produce. Header beat expected when
// ME_DRAIN_HDR_EN is defined.
// ---------------------------------------------------------------------------
module tb_me_result_drain;

   localparam int M_SIZE = 3072;
   localparam int OW     = 64;
   localparam int NWORDS = M_SIZE / OW;
`ifdef ME_DRAIN_HDR_EN
   localparam int NBEATS = NWORDS + 1;
`else
   localparam int NBEATS = NWORDS;
`endif
   localparam int LIMIT  = 4000;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              done = 1'b0;
   logic [M_SIZE-1:0] z = '0;
   logic [3:0]        num_out = 4'd0;
   logic [OW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              out_last;
   logic [3:0]        out_num;
   logic              busy;
   logic              overflow;
   logic              clr_ovf = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [OW-1:0] exp_data[$];
   logic          exp_last[$];
   logic [3:0]    exp_num[$];
   logic          exp_ovf = 1'b0;

   int cyc, hs;
   logic [M_SIZE-1:0] zpat;

   me_result_drain #(.M_SIZE(M_SIZE), .OUT_WIDTH(OW), .NUM_W(4)) dut (
      .clk(clk), .rst(rst), .done(done), .z(z), .num_out(num_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_num(out_num), .busy(busy),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [M_SIZE-1:0] rand_z();
      logic [M_SIZE-1:0] r;
      for (int i = 0; i < M_SIZE / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Expected beat list of one result: optional header, then words LSW first
   task automatic push_result(input logic [M_SIZE-1:0] zz, input logic [3:0] tag);
`ifdef ME_DRAIN_HDR_EN
      exp_data.push_back({48'd0, 8'(NWORDS), 4'd0, tag});
      exp_last.push_back(1'b0);
      exp_num.push_back(tag);
`endif
      for (int k = 0; k < NWORDS; k++) begin
         exp_data.push_back(zz[k*OW +: OW]);
         exp_last.push_back(k == NWORDS - 1);
         exp_num.push_back(tag);
      end
   endtask

   // Called at a negedge with the block idle: pulse done at the next edge
   task automatic start(input logic [M_SIZE-1:0] zz, input logic [3:0] tag);
      done = 1'b1;
      z = zz;
      num_out = tag;
      push_result(zz, tag);
   endtask

   // mode 0: ready=1, 1: ready 1,0,0 repeating, 2: random ready
   task automatic run(input int mode, input int drop_beat, input bit chain,
                      input int abort_beat, input bit hold_clr,
                      output int cycles, output int nhs);
      int guard = 0;
      bit chn = chain;
      bit drop_now;
      logic r;
      logic [M_SIZE-1:0] nz;
      cycles = 0;
      nhs = 0;
      clr_ovf = hold_clr;
      @(negedge clk);
      done = 1'b0;
      while (exp_data.size() > 0 && guard < LIMIT) begin
         if (nhs == abort_beat) break;
         guard++;
         cycles++;
         chk("valid", out_valid, 1);
         chk("busy", busy, 1);
         chk("data", out_data, exp_data[0]);
         chk("last", out_last, exp_last[0]);
         chk("num", out_num, exp_num[0]);
         chk("ovf", overflow, exp_ovf);
         case (mode)
            0: r = 1'b1;
            1: r = (cycles % 3 == 1);
            default: r = 1'(($urandom_range(0, 1)));
         endcase
         out_ready = r;
         drop_now = 1'b0;
         if (r) begin
            if (chn && exp_last[0]) begin
               void'(exp_data.pop_front()); void'(exp_last.pop_front()); void'(exp_num.pop_front());
               nz = rand_z();
               start(nz, 4'd4);
               chn = 1'b0;
            end else begin
               void'(exp_data.pop_front()); void'(exp_last.pop_front()); void'(exp_num.pop_front());
               if (nhs == drop_beat) begin
                  done = 1'b1;
                  z = rand_z();
                  num_out = 4'(($urandom));
                  drop_now = 1'b1;
               end
            end
            nhs++;
         end
         exp_ovf = drop_now ? 1'b1 : (clr_ovf ? 1'b0 : exp_ovf);
         @(negedge clk);
         done = 1'b0;
      end
      chk("run_bounded", (guard < LIMIT), 1);
      clr_ovf = 1'b0;
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_last", out_last, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_data", out_data, 0);
      chk("rst_num", out_num, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_valid", out_valid, 0);

      // Pattern result, ready always 1: exact NBEATS cycles, idle after
      for (int i = 0; i < NWORDS; i++) zpat[i*OW +: OW] = {8{8'(i)}};
      start(zpat, 4'd3);
      run(0, -1, 1'b0, -1, 1'b0, cyc, hs);
      chk("drain_cycles", cyc, NBEATS);
      chk("drain_hs", hs, NBEATS);
      chk("end_valid", out_valid, 0);
      chk("end_busy", busy, 0);

      // Same stimulus, ready 1,0,0 pattern
      start(zpat, 4'd3);
      run(1, -1, 1'b0, -1, 1'b0, cyc, hs);
      chk("toggle_hs", hs, NBEATS);
      chk("toggle_end_valid", out_valid, 0);

      // Random data, random ready
      start(rand_z(), 4'(($urandom)));
      run(2, -1, 1'b0, -1, 1'b0, cyc, hs);
      chk("rand_hs", hs, NBEATS);

      // Dropped done during beat 10, stream unchanged; then clear
      start(rand_z(), 4'd5);
      run(0, 10, 1'b0, -1, 1'b0, cyc, hs);
      chk("drop_hs", hs, NBEATS);
      chk("drop_ovf_sticky", overflow, 1);
      chk("drop_idle", out_valid, 0);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      exp_ovf = 1'b0;
      chk("clr_ovf", overflow, 0);

      // Clear held during a drop: set wins for that cycle, then cleared
      start(rand_z(), 4'd6);
      run(2, 5, 1'b0, -1, 1'b1, cyc, hs);
      chk("setwin_hs", hs, NBEATS);
      chk("setwin_ovf_end", overflow, 0);

      // Done coincident with last handshake: back-to-back, no overflow
      start(rand_z(), 4'd3);
      run(0, -1, 1'b1, -1, 1'b0, cyc, hs);
      chk("chain_hs", hs, 2 * NBEATS);
      chk("chain_cycles", cyc, 2 * NBEATS);
      chk("chain_ovf", overflow, 0);

      // Reset at beat 20: outputs drop before the next edge, then stay idle
      start(rand_z(), 4'd9);
      run(0, -1, 1'b0, 20, 1'b0, cyc, hs);
      chk("abort_pre_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_data", out_data, 0);
      chk("abort_num", out_num, 0);
      exp_data.delete();
      exp_last.delete();
      exp_num.delete();
      exp_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_idle", out_valid, 0);
      end

      // A fresh result after the abort streams normally
      start(rand_z(), 4'd2);
      run(0, -1, 1'b0, -1, 1'b0, cyc, hs);
      chk("post_rst_hs", hs, NBEATS);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
